// File: rtl/dircc_avalon_st_pkg.sv
// -----------------------------------------------------------------------------
// dircc_avalon_st_pkg
// Shared definitions for the DiRCC Avalon-ST packet source: register map
// addresses, CTRL register bit positions and the transmit FSM state encoding.
// -----------------------------------------------------------------------------
package dircc_avalon_st_pkg;

  // Avalon-MM register addresses
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_LEN    = 2'd1;
  localparam logic [1:0] ADDR_SEED   = 2'd2;
  localparam logic [1:0] ADDR_PKTCNT = 2'd3;

  // CTRL bit positions (START on write and BUSY on read share bit 0)
  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY  = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_DONE  = 15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/dircc_avalon_st_pkt_framer.sv
// -----------------------------------------------------------------------------
// dircc_avalon_st_pkt_framer
// Beat counter and sop/eop/empty framing for a packet of `len` bytes carried on
// a BYTES-wide stream. The counter advances on every accepted beat and wraps
// to zero after the eop beat, so it is ready for the next packet immediately.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   len           packet length in bytes (held stable while a packet is sent)
//   xfer          one-cycle pulse per accepted beat (valid && ready)
//   beat          index of the beat currently presented
//   sop, eop      first / last beat of the packet
//   empty         unused bytes on the eop beat, 0 on all other beats
// -----------------------------------------------------------------------------
module dircc_avalon_st_pkt_framer #(
  parameter int BYTES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] len,
  input  logic        xfer,
  output logic [15:0] beat,
  output logic        sop,
  output logic        eop,
  output logic [1:0]  empty
);

  localparam int         SHIFT  = $clog2(BYTES);
  localparam logic [1:0] MASK   = 2'(BYTES - 1);
  localparam logic [1:0] BYTES2 = 2'(BYTES);

  logic [16:0] beats;
  logic [15:0] last_beat;
  logic [15:0] beat_q;

  // ceil(len / BYTES) computed one bit wider so len = 0xFFFF cannot overflow
  assign beats     = (17'(len) + 17'(BYTES - 1)) >> SHIFT;
  assign last_beat = 16'(beats - 17'd1);

  assign beat  = beat_q;
  assign sop   = (beat_q == 16'd0);
  assign eop   = (beat_q == last_beat);
  // (BYTES - len mod BYTES) mod BYTES == BEATS*BYTES - len
  assign empty = eop ? ((BYTES2 - (len[1:0] & MASK)) & MASK) : 2'd0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_q <= '0;
    end else if (xfer) begin
      beat_q <= eop ? 16'd0 : beat_q + 16'd1;
    end
  end

endmodule

// File: rtl/dircc_avalon_st_packet_source.sv
// -----------------------------------------------------------------------------
// dircc_avalon_st_packet_source
// Avalon-ST test-packet generator controlled through a 16-bit Avalon-MM slave.
// Each packet is LEN bytes long; beat k carries SEED + k. With CONT set the
// source streams back-to-back packets without a valid gap.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   data, empty, startofpacket,
//   endofpacket, valid, ready    Avalon-ST source (readyLatency 0)
//   address, writedata, write_n,
//   readdata, read_n             Avalon-MM slave, 1-cycle read latency
// -----------------------------------------------------------------------------
module dircc_avalon_st_packet_source
  import dircc_avalon_st_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            empty,
  output logic                  endofpacket,
  output logic                  startofpacket,
  output logic                  valid,
  input  logic                  ready,
  input  logic [1:0]            address,
  input  logic [15:0]           writedata,
  input  logic                  write_n,
  output logic [15:0]           readdata,
  input  logic                  read_n
);

  localparam int BYTES = DATA_WIDTH / 8;

  state_t      state_q, state_d;
  logic [15:0] len_q, seed_q, pktcnt_q;
  logic        cont_q, done_q;
  logic [15:0] readdata_q, rd_mux;

  logic        busy, xfer, eop_xfer, start_req, zero_start;
  logic        wr_ctrl, wr_len, wr_seed, wr_pktcnt;
  logic [15:0] f_beat;
  logic        f_sop, f_eop;
  logic [1:0]  f_empty;

  assign busy      = (state_q == ST_SEND);
  assign wr_ctrl   = !write_n && (address == ADDR_CTRL);
  assign wr_len    = !write_n && (address == ADDR_LEN)  && !busy;
  assign wr_seed   = !write_n && (address == ADDR_SEED) && !busy;
  assign wr_pktcnt = !write_n && (address == ADDR_PKTCNT);

  // START is only honoured from IDLE; a zero-length START completes at once.
  assign start_req  = wr_ctrl && writedata[CTRL_START] && !busy;
  assign zero_start = start_req && (len_q == 16'd0);

  assign xfer     = busy && ready;
  assign eop_xfer = xfer && f_eop;

  dircc_avalon_st_pkt_framer #(
    .BYTES (BYTES)
  ) u_framer (
    .clk     (clk),
    .reset_n (reset_n),
    .len     (len_q),
    .xfer    (xfer),
    .beat    (f_beat),
    .sop     (f_sop),
    .eop     (f_eop),
    .empty   (f_empty)
  );

  // --- FSM: state register ---------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --- FSM: next state -------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_req && !zero_start) state_d = ST_SEND;
      // CONT is sampled as stored at the eop transfer
      ST_SEND: if (eop_xfer && !cont_q)      state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  // --- FSM: outputs ----------------------------------------------------------
  // Stream outputs depend only on registered state, so they are stable while
  // the sink stalls.
  always_comb begin
    valid         = 1'b0;
    startofpacket = 1'b0;
    endofpacket   = 1'b0;
    empty         = 2'd0;
    data          = '0;
    if (state_q == ST_SEND) begin
      valid         = 1'b1;
      startofpacket = f_sop;
      endofpacket   = f_eop;
      empty         = f_empty;
      data          = DATA_WIDTH'(seed_q) + DATA_WIDTH'(f_beat);
    end
  end

  // --- Register file ---------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q    <= '0;
      seed_q   <= '0;
      pktcnt_q <= '0;
      cont_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (wr_len)  len_q  <= writedata;
      if (wr_seed) seed_q <= writedata;
      if (wr_ctrl) cont_q <= writedata[CTRL_CONT];

      // completion set beats a simultaneous host clear
      if (eop_xfer || zero_start) begin
        done_q <= 1'b1;
      end else if (wr_ctrl && writedata[CTRL_DONE]) begin
        done_q <= 1'b0;
      end

      // a clear coinciding with a completion counts that completion
      if (eop_xfer) begin
        pktcnt_q <= wr_pktcnt ? 16'd1 : pktcnt_q + 16'd1;
      end else if (wr_pktcnt) begin
        pktcnt_q <= 16'd0;
      end
    end
  end

  // --- Read path -------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    unique case (address)
      ADDR_CTRL: begin
        rd_mux[CTRL_BUSY] = busy;
        rd_mux[CTRL_CONT] = cont_q;
        rd_mux[CTRL_DONE] = done_q;
      end
      ADDR_LEN:    rd_mux = len_q;
      ADDR_SEED:   rd_mux = seed_q;
      ADDR_PKTCNT: rd_mux = pktcnt_q;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else if (!read_n) begin
      readdata_q <= rd_mux;
    end
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_dircc_avalon_st_packet_source.sv
// -----------------------------------------------------------------------------
// tb_dircc_avalon_st_packet_source
// Self-checking bench: packets expected from LEN/SEED arithmetic are queued and
// every accepted beat is matched against that queue; stalls are checked for
// stability, and register reads are compared against known values.
// -----------------------------------------------------------------------------
module tb_dircc_avalon_st_packet_source;

  localparam int DW    = 32;
  localparam int BYTES = DW / 8;

  localparam logic [1:0] A_CTRL = 2'd0, A_LEN = 2'd1, A_SEED = 2'd2, A_PKT = 2'd3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] data;
  logic [1:0]    empty;
  logic          endofpacket, startofpacket, valid, ready;
  logic [1:0]    address;
  logic [15:0]   writedata;
  logic          write_n;
  logic [15:0]   readdata;
  logic          read_n;

  dircc_avalon_st_packet_source #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .data          (data),
    .empty         (empty),
    .endofpacket   (endofpacket),
    .startofpacket (startofpacket),
    .valid         (valid),
    .ready         (ready),
    .address       (address),
    .writedata     (writedata),
    .write_n       (write_n),
    .readdata      (readdata),
    .read_n        (read_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [1:0]    empty;
  } beat_t;

  beat_t      exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_xfer = 0;
  logic [1:0] last_empty = 2'd0;
  logic       prev_stall = 1'b0;
  beat_t      prev_beat;

  // Reference model: one packet of len bytes starting at seed.
  task automatic push_packet(input int len, input int seed);
    int    beats;
    beat_t b;
    beats = (len + BYTES - 1) / BYTES;
    for (int k = 0; k < beats; k++) begin
      b.data  = DW'(seed + k);
      b.sop   = (k == 0);
      b.eop   = (k == beats - 1);
      b.empty = b.eop ? 2'(beats * BYTES - len) : 2'd0;
      exp_q.push_back(b);
    end
  endtask

  // One clock cycle. Stream outputs are observed at the falling edge, inputs
  // are changed by callers 1 ns after the rising edge.
  task automatic tick();
    beat_t cur, e;
    @(negedge clk);
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      cur = '{data, startofpacket, endofpacket, empty};
      if (prev_stall) begin
        n_cmp++;
        if (!valid || cur !== prev_beat) begin
          n_bad++;
          $display("FAIL stall_hold: got valid=%b beat=%h, required valid=1 beat=%h", valid, cur, prev_beat);
        end
      end
      if (valid && ready) begin
        n_xfer++;
        last_empty = empty;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL extra_beat: got beat=%h, required no transfer", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_bad++;
            $display("FAIL beat: got %h, required %h (data/sop/eop/empty)", cur, e);
          end
        end
      end
      prev_stall = valid && !ready;
      prev_beat  = cur;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [15:0] wd);
    address = a; writedata = wd; write_n = 1'b0;
    tick();
    write_n = 1'b1;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [15:0] v);
    address = a; read_n = 1'b0;
    tick();
    read_n = 1'b1;
    v = readdata;
  endtask

  task automatic wait_valid(input int budget);
    int i = 0;
    while (!valid && i < budget) begin tick(); i++; end
    n_cmp++;
    if (!valid) begin n_bad++; $display("FAIL wait_valid: got valid=0 after %0d cycles, required 1", budget); end
  endtask

  task automatic drain(input int budget, input bit rnd_ready);
    int i = 0;
    while (exp_q.size() > 0 && i < budget) begin
      if (rnd_ready) ready = ($urandom_range(0, 9) < 7);
      tick(); i++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d beats outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_status();
    reg_write(A_PKT, 16'h0);
    reg_write(A_CTRL, 16'h8000);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [15:0] v;
    #12;
    n_cmp++;
    if ({valid, startofpacket, endofpacket, empty, data, readdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b sop=%b eop=%b empty=%0d data=%h rd=%h, required all 0",
               valid, startofpacket, endofpacket, empty, data, readdata);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      reg_read(2'(a), v);
      n_cmp++;
      if (v !== 16'h0) begin n_bad++; $display("FAIL reset_reg%0d: got %h, required 0000", a, v); end
    end
  endtask

  task automatic test_basic();
    logic [15:0] v;
    int x0;
    ready = 1'b1;
    clear_status();
    reg_write(A_LEN, 16'd8);
    reg_write(A_SEED, 16'h0010);
    push_packet(8, 'h10);
    x0 = n_xfer;
    reg_write(A_CTRL, 16'h0001);
    drain(50, 1'b0);
    idle(3);
    n_cmp++;
    if (n_xfer - x0 != 2) begin n_bad++; $display("FAIL basic_xfers: got %0d, required 2", n_xfer - x0); end
    reg_read(A_CTRL, v);
    n_cmp++;
    if (v !== 16'h8000) begin n_bad++; $display("FAIL basic_ctrl: got %h, required 8000", v); end
    reg_read(A_PKT, v);
    n_cmp++;
    if (v !== 16'd1) begin n_bad++; $display("FAIL basic_pktcnt: got %h, required 0001", v); end
  endtask

  task automatic test_stall();
    int x0;
    ready = 1'b0;
    reg_write(A_LEN, 16'd5);
    reg_write(A_SEED, 16'hBEEF);
    push_packet(5, 'hBEEF);
    x0 = n_xfer;
    reg_write(A_CTRL, 16'h0001);
    wait_valid(10);
    ready = 1'b1; tick();
    ready = 1'b0; tick(); tick();
    ready = 1'b1; tick();
    idle(3);
    n_cmp++;
    if (n_xfer - x0 != 2) begin n_bad++; $display("FAIL stall_xfers: got %0d, required 2", n_xfer - x0); end
    n_cmp++;
    if (last_empty !== 2'd3) begin n_bad++; $display("FAIL stall_empty: got %0d, required 3", last_empty); end
    drain(1, 1'b0);
  endtask

  task automatic test_single_and_zero();
    logic [15:0] v;
    int vcnt = 0;
    ready = 1'b1;
    reg_write(A_LEN, 16'd3);
    reg_write(A_SEED, 16'h0042);
    push_packet(3, 'h42);
    reg_write(A_CTRL, 16'h0001);
    drain(20, 1'b0);
    n_cmp++;
    if (last_empty !== 2'd1) begin n_bad++; $display("FAIL single_empty: got %0d, required 1", last_empty); end
    reg_write(A_CTRL, 16'h8000);
    reg_write(A_LEN, 16'd0);
    reg_write(A_CTRL, 16'h0001);
    reg_read(A_CTRL, v);
    n_cmp++;
    if (v !== 16'h8000) begin n_bad++; $display("FAIL zero_len_ctrl: got %h, required 8000", v); end
    for (int i = 0; i < 5; i++) begin if (valid) vcnt++; tick(); end
    n_cmp++;
    if (vcnt != 0) begin n_bad++; $display("FAIL zero_len_valid: got %0d valid cycles, required 0", vcnt); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    int x0;
    ready = 1'b0;
    clear_status();
    reg_write(A_LEN, 16'd4);
    reg_write(A_SEED, 16'h0100);
    for (int p = 0; p < 6; p++) push_packet(4, 'h100);
    reg_write(A_CTRL, 16'h0003);
    wait_valid(10);
    x0 = n_xfer;
    ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    ready = 1'b0;
    n_cmp++;
    if (n_xfer - x0 != 6 || !valid) begin
      n_bad++;
      $display("FAIL b2b_no_gap: got %0d xfers valid=%b, required 6 valid=1", n_xfer - x0, valid);
    end
    reg_read(A_PKT, v);
    n_cmp++;
    if (v !== 16'd6) begin n_bad++; $display("FAIL b2b_pktcnt: got %0d, required 6", v); end
    reg_write(A_CTRL, 16'h0000);
    push_packet(4, 'h100);
    ready = 1'b1;
    drain(20, 1'b0);
    idle(3);
    reg_read(A_CTRL, v);
    n_cmp++;
    if (v !== 16'h8000) begin n_bad++; $display("FAIL b2b_stop_ctrl: got %h, required 8000", v); end
    reg_read(A_PKT, v);
    n_cmp++;
    if (v !== 16'd7) begin n_bad++; $display("FAIL b2b_stop_pktcnt: got %0d, required 7", v); end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] v;
    ready = 1'b0;
    clear_status();
    reg_write(A_LEN, 16'd12);
    reg_write(A_SEED, 16'h7000);
    push_packet(12, 'h7000);
    reg_write(A_CTRL, 16'h0001);
    wait_valid(10);
    reg_read(A_CTRL, v);
    n_cmp++;
    if (v !== 16'h0001) begin n_bad++; $display("FAIL busy_ctrl: got %h, required 0001", v); end
    reg_write(A_LEN, 16'd4);
    reg_write(A_CTRL, 16'h0001);
    ready = 1'b1;
    drain(30, 1'b0);
    idle(6);
    reg_read(A_LEN, v);
    n_cmp++;
    if (v !== 16'd12) begin n_bad++; $display("FAIL busy_len: got %0d, required 12", v); end
    reg_read(A_PKT, v);
    n_cmp++;
    if (v !== 16'd1) begin n_bad++; $display("FAIL busy_pktcnt: got %0d, required 1", v); end
  endtask

  task automatic test_collision();
    logic [15:0] v;
    ready = 1'b0;
    reg_write(A_CTRL, 16'h8000);
    reg_write(A_LEN, 16'd4);
    push_packet(4, 'h7000);
    reg_write(A_CTRL, 16'h0001);
    wait_valid(10);
    ready = 1'b1;
    reg_write(A_CTRL, 16'h8000);
    ready = 1'b0;
    reg_read(A_CTRL, v);
    n_cmp++;
    if (v !== 16'h8000) begin n_bad++; $display("FAIL done_set_wins: got %h, required 8000", v); end
    push_packet(4, 'h7000);
    reg_write(A_CTRL, 16'h0001);
    wait_valid(10);
    ready = 1'b1;
    reg_write(A_PKT, 16'h1234);
    ready = 1'b0;
    reg_read(A_PKT, v);
    n_cmp++;
    if (v !== 16'd1) begin n_bad++; $display("FAIL pktcnt_collision: got %0d, required 1", v); end
    drain(1, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] v;
    int len, seed;
    clear_status();
    for (int p = 0; p < 8; p++) begin
      ready = 1'b0;
      len  = (p == 0) ? 1 : $urandom_range(1, 40);
      seed = (p == 1) ? 'hFFFF : $urandom_range(0, 65535);
      reg_write(A_LEN, 16'(len));
      reg_write(A_SEED, 16'(seed));
      push_packet(len, seed);
      reg_write(A_CTRL, 16'h0001);
      drain(200, 1'b1);
      ready = 1'b0;
      idle(2);
    end
    reg_read(A_PKT, v);
    n_cmp++;
    if (v !== 16'd8) begin n_bad++; $display("FAIL random_pktcnt: got %0d, required 8", v); end
  endtask

  task automatic test_mid_reset();
    logic [15:0] v;
    int x0, i;
    ready = 1'b1;
    reg_write(A_LEN, 16'd40);
    reg_write(A_SEED, 16'h0A00);
    reg_write(A_CTRL, 16'h0003);
    push_packet(40, 'hA00);
    x0 = n_xfer;
    i = 0;
    while (n_xfer - x0 < 3 && i < 20) begin tick(); i++; end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({valid, startofpacket, endofpacket, data} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got valid=%b sop=%b eop=%b data=%h, required all 0",
               valid, startofpacket, endofpacket, data);
    end
    exp_q.delete();
    tick(); tick();
    reset_n = 1'b1;
    ready = 1'b0;
    for (int a = 0; a < 4; a++) begin
      reg_read(2'(a), v);
      n_cmp++;
      if (v !== 16'h0) begin n_bad++; $display("FAIL post_reset_reg%0d: got %h, required 0000", a, v); end
    end
    n_cmp++;
    if (valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid: got %b, required 0", valid); end
  endtask

  initial begin
    reset_n   = 1'b0;
    ready     = 1'b0;
    address   = 2'd0;
    writedata = 16'h0;
    write_n   = 1'b1;
    read_n    = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_single_and_zero();
    test_back_to_back();
    test_busy_ignore();
    test_collision();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dircc_avalon_st_packet_source.md
Name: dircc_avalon_st_packet_source

Overview:
- Avalon-ST source that generates test packets for DiRCC streaming links.
- Acts as the transmit-side counterpart of the stream sink/terminal blocks.
- Host configures length and seed, then triggers packets through a small 16-bit Avalon-MM slave.
- Packets carry an incrementing word pattern with correct sop/eop/empty framing. Used to exercise and bring up downstream stream consumers.

Parameters:
- DATA_WIDTH, 32, stream data width in bits. Legal values: 8, 16, 32. BYTES = DATA_WIDTH/8.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- data  out  DATA_WIDTH  stream data
- empty  out  2  count of unused bytes on the eop beat; 0 on all other beats
- endofpacket  out  1  last beat of packet
- startofpacket  out  1  first beat of packet
- valid  out  1  beat present
- ready  in  1  sink accepts beat (readyLatency 0)
- address  in  2  register select
- writedata  in  16  register write data
- write_n  in  1  active-low write strobe
- readdata  out  16  registered read data
- read_n  in  1  active-low read strobe

Behaviour:
- Reset: valid, startofpacket, endofpacket = 0; data, empty, readdata = 0; all registers = 0; FSM in IDLE. Reset is asynchronous and may occur mid-packet: valid drops immediately and the packet is abandoned, with no partial eop.
- Register map:
  - 0 CTRL. Write: bit0 START (self-clearing pulse), bit1 CONT (stored), bit15 = 1 clears DONE. Read: bit0 BUSY, bit1 CONT, bit15 DONE (sticky).
  - 1 LEN. Packet length in bytes, 16-bit.
  - 2 SEED. First data word of each packet.
  - 3 PKTCNT. Completed packets, wraps 0xFFFF -> 0. Any write clears it.
- Register writes to LEN and SEED while BUSY are ignored. A CTRL write while BUSY updates only CONT and DONE-clear; START is ignored.
- Reads: readdata is updated on the clk edge where read_n = 0, giving 1-cycle read latency. readdata holds its value otherwise.
- Beats per packet: BEATS = ceil(LEN/BYTES). Last-beat empty = BEATS*BYTES - LEN.
- Data pattern: beat k carries SEED + k, zero-extended or truncated to DATA_WIDTH, modulo 2^DATA_WIDTH.
- FSM states:
  - IDLE: on START with LEN != 0, go to SEND; valid rises on the next cycle. On START with LEN == 0, send nothing, set DONE, and stay in IDLE.
  - SEND: valid = 1. Beat counter advances only on valid && ready. sop = 1 on beat 0; eop = 1 on beat BEATS-1. When LEN <= BYTES, sop and eop are both asserted on a single beat.
  - On the eop transfer: PKTCNT increments and DONE sets. If CONT = 1, the next packet's sop beat is presented on the following cycle, giving back-to-back packets with no valid gap. If CONT = 0, go to IDLE.
- Handshake: while valid && !ready, data, sop, eop and empty are held stable. valid never deasserts mid-packet except on reset.
- CONT cleared during SEND: the current packet completes, then the FSM returns to IDLE.
- DONE-clear in the same cycle as an eop transfer: the set wins and DONE = 1.
- PKTCNT write in the same cycle as an eop transfer: the result is PKTCNT = 1.
- BUSY = (state == SEND).

Decomposition:
- Shared package dircc_avalon_st_pkg holds:
  - register address constants CTRL/LEN/SEED/PKTCNT;
  - CTRL bit positions;
  - the state encoding IDLE/SEND.
- One natural sub-module: dircc_avalon_st_pkt_framer. It takes LEN and the beat-transfer pulse and produces the beat counter, sop, eop and empty. It can be reused by future stream transmitters.
- The register file and FSM stay in the top module.

Test Plan:
- LEN=8, SEED=0x0010, DATA_WIDTH=32, ready tied 1, START -> 2 beats with data 0x10, 0x11. sop on beat 0; eop and empty=0 on beat 1. DONE=1 and PKTCNT=1 afterwards.
- LEN=5, ready toggling 1,0,0,1 -> beat 1 is held stable through both stall cycles. eop beat shows empty=3. Exactly 2 transfers occur.
- LEN=3 -> single beat with sop=eop=1 and empty=1. LEN=0 + START -> valid stays 0 and DONE=1 immediately.
- CONT=1, LEN=4, ready=1 for 6 cycles -> 6 consecutive single-beat packets with no valid gap, PKTCNT=6. Then clear CONT mid-stream -> current packet ends and BUSY falls.
- START during BUSY, and a LEN write during BUSY -> both are ignored, so the packet length is unchanged.
- Reset asserted mid-packet -> valid=0 asynchronously and all registers read 0 after release.
